// File: rtl/mini_src_pkg.sv
// Shared Mini SRC control definitions: opcodes, ALU op bit positions,
// sequencer state encoding, instruction classes and datapath strobe bundle.
package mini_src_pkg;

    // Register-register ALU opcodes, IR[31:27]
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpRor  = 5'b00111;
    localparam logic [4:0] OpRol  = 5'b01000;
    localparam logic [4:0] OpShr  = 5'b01001;
    localparam logic [4:0] OpShra = 5'b01010;
    localparam logic [4:0] OpShl  = 5'b01011;
    localparam logic [4:0] OpNeg  = 5'b01110;
    localparam logic [4:0] OpMul  = 5'b01111;
    localparam logic [4:0] OpDiv  = 5'b10000;
    localparam logic [4:0] OpNot  = 5'b10001;

    // Bit positions within the one-hot alu_op vector
    localparam int unsigned AluAdd    = 0;
    localparam int unsigned AluSub    = 1;
    localparam int unsigned AluAnd    = 2;
    localparam int unsigned AluOr     = 3;
    localparam int unsigned AluShr    = 4;
    localparam int unsigned AluShra   = 5;
    localparam int unsigned AluShl    = 6;
    localparam int unsigned AluRor    = 7;
    localparam int unsigned AluRol    = 8;
    localparam int unsigned AluNeg    = 9;
    localparam int unsigned AluNot    = 10;
    localparam int unsigned AluMul    = 11;
    localparam int unsigned AluDiv    = 12;
    localparam int unsigned AluInc    = 13;
    localparam int unsigned NumAluOps = 14;

    typedef enum logic [3:0] {
        StIdle, StT0, StT1, StT1w, StT2, StDec, StT3, StT4, StT5, StT6, StHalt
    } state_e;

    typedef enum logic [1:0] {
        ClsBin, ClsUnary, ClsHilo, ClsBad
    } iclass_e;

    // Single-bit datapath strobes, registered as one bundle
    typedef struct packed {
        logic pc_out;
        logic pc_in;
        logic mar_in;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic zlow_out;
        logic zhigh_out;
        logic hi_in;
        logic lo_in;
        logic read;
        logic inc_pc;
    } strobes_t;

endpackage

// File: rtl/instr_decode.sv
// Opcode classifier: maps an opcode to its instruction class and the
// one-hot ALU operation it requests. Purely combinational.
module instr_decode
    import mini_src_pkg::*;
#(
    parameter int unsigned OP_W = 5
) (
    input  logic [OP_W-1:0]      i_op,
    output logic [1:0]           o_class,
    output logic [NumAluOps-1:0] o_alu_op
);

    // Opcode lookup; anything not listed is reported as ClsBad
    always_comb begin
        o_class  = ClsBad;
        o_alu_op = '0;
        case (i_op)
            OpAdd:  begin o_class = ClsBin;   o_alu_op[AluAdd]  = 1'b1; end
            OpSub:  begin o_class = ClsBin;   o_alu_op[AluSub]  = 1'b1; end
            OpAnd:  begin o_class = ClsBin;   o_alu_op[AluAnd]  = 1'b1; end
            OpOr:   begin o_class = ClsBin;   o_alu_op[AluOr]   = 1'b1; end
            OpRor:  begin o_class = ClsBin;   o_alu_op[AluRor]  = 1'b1; end
            OpRol:  begin o_class = ClsBin;   o_alu_op[AluRol]  = 1'b1; end
            OpShr:  begin o_class = ClsBin;   o_alu_op[AluShr]  = 1'b1; end
            OpShra: begin o_class = ClsBin;   o_alu_op[AluShra] = 1'b1; end
            OpShl:  begin o_class = ClsBin;   o_alu_op[AluShl]  = 1'b1; end
            OpNeg:  begin o_class = ClsUnary; o_alu_op[AluNeg]  = 1'b1; end
            OpNot:  begin o_class = ClsUnary; o_alu_op[AluNot]  = 1'b1; end
            OpMul:  begin o_class = ClsHilo;  o_alu_op[AluMul]  = 1'b1; end
            OpDiv:  begin o_class = ClsHilo;  o_alu_op[AluDiv]  = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Hardwired control sequencer for Mini SRC register-register ALU instructions:
// fetch (with optional memory wait states), decode, and execute for binary,
// unary and MUL/DIV forms. Outputs are registered Moore decodes of the state.
module alu_instr_sequencer
    import mini_src_pkg::*;
#(
    parameter int unsigned NREGS    = 16,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned OP_W     = 5
) (
    input  logic                 i_clock,
    input  logic                 i_clear,
    input  logic                 i_start,
    input  logic                 i_run,
    input  logic [31:0]          i_ir,
    output logic [NREGS-1:0]     o_rin,
    output logic [NREGS-1:0]     o_rout,
    output logic                 o_pc_out,
    output logic                 o_pc_in,
    output logic                 o_mar_in,
    output logic                 o_mdr_in,
    output logic                 o_mdr_out,
    output logic                 o_ir_in,
    output logic                 o_y_in,
    output logic                 o_z_in,
    output logic                 o_zlow_out,
    output logic                 o_zhigh_out,
    output logic                 o_hi_in,
    output logic                 o_lo_in,
    output logic                 o_read,
    output logic                 o_inc_pc,
    output logic [NumAluOps-1:0] o_alu_op,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_illegal
);

    localparam logic [2:0] WaitReload = (MEM_WAIT > 0) ? 3'(MEM_WAIT - 1) : 3'd0;

    // State and latched instruction fields
    state_e               r_state, w_state_d;
    logic [2:0]           r_wait_cnt, w_wait_cnt_d;
    logic [REG_W-1:0]     r_ra, r_rb, r_rc, w_ra_d, w_rb_d, w_rc_d;
    iclass_e              r_class, w_class_d;
    logic [NumAluOps-1:0] r_alu, w_alu_d;
    logic                 r_illegal, w_illegal_d;

    // Registered outputs and their next values
    strobes_t             r_strb, w_strb_d;
    logic [NREGS-1:0]     r_rin, r_rout, w_rin_d, w_rout_d;
    logic [NumAluOps-1:0] r_alu_out, w_alu_out_d;
    logic                 r_busy, r_done, w_busy_d, w_done_d;

    // Instruction fields straight from IR, used only while in DEC
    logic [OP_W-1:0]      w_op;
    logic [REG_W-1:0]     w_ir_ra, w_ir_rb, w_ir_rc;
    logic [1:0]           w_dec_class;
    logic [NumAluOps-1:0] w_dec_alu;
    logic                 w_reg_bad;
    logic                 w_unused_ir;

    assign w_op        = i_ir[31 -: OP_W];
    assign w_ir_ra     = i_ir[26 -: REG_W];
    assign w_ir_rb     = i_ir[26 - REG_W -: REG_W];
    assign w_ir_rc     = i_ir[26 - 2 * REG_W -: REG_W];
    assign w_unused_ir = ^i_ir[26 - 3 * REG_W:0];

    instr_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .i_op     (w_op),
        .o_class  (w_dec_class),
        .o_alu_op (w_dec_alu)
    );

    // A register field outside the file is illegal only if the class uses it
    always_comb begin
        w_reg_bad = (32'(w_ir_ra) >= NREGS) || (32'(w_ir_rb) >= NREGS);
        if (iclass_e'(w_dec_class) == ClsBin && 32'(w_ir_rc) >= NREGS) begin
            w_reg_bad = 1'b1;
        end
    end

    // Next-state sequencing and field latching
    always_comb begin
        w_state_d    = r_state;
        w_wait_cnt_d = r_wait_cnt;
        w_ra_d       = r_ra;
        w_rb_d       = r_rb;
        w_rc_d       = r_rc;
        w_class_d    = r_class;
        w_alu_d      = r_alu;
        w_illegal_d  = r_illegal;
        case (r_state)
            StIdle: if (i_start) w_state_d = StT0;
            StT0:   w_state_d = StT1;
            StT1: begin
                if (MEM_WAIT > 0) begin
                    w_state_d    = StT1w;
                    w_wait_cnt_d = WaitReload;
                end else begin
                    w_state_d = StT2;
                end
            end
            StT1w: begin
                if (r_wait_cnt == 3'd0) w_state_d = StT2;
                else                    w_wait_cnt_d = r_wait_cnt - 3'd1;
            end
            StT2:   w_state_d = StDec;
            StDec: begin
                w_ra_d    = w_ir_ra;
                w_rb_d    = w_ir_rb;
                w_rc_d    = w_ir_rc;
                w_class_d = iclass_e'(w_dec_class);
                w_alu_d   = w_dec_alu;
                if (iclass_e'(w_dec_class) == ClsBad || w_reg_bad) begin
                    w_state_d   = StHalt;
                    w_illegal_d = 1'b1;
                end else begin
                    w_state_d = StT3;
                end
            end
            StT3:   w_state_d = StT4;
            StT4:   w_state_d = StT5;
            StT5: begin
                if (r_class == ClsHilo) w_state_d = StT6;
                else                    w_state_d = i_run ? StT0 : StIdle;
            end
            StT6:   w_state_d = i_run ? StT0 : StIdle;
            StHalt: w_state_d = StHalt;
            default: w_state_d = StIdle;
        endcase
    end

    // Moore output decode of the upcoming state, so registers line up with it
    always_comb begin
        w_strb_d    = '0;
        w_alu_out_d = '0;
        w_rin_d     = '0;
        w_rout_d    = '0;
        w_done_d    = 1'b0;
        w_busy_d    = (w_state_d != StIdle) && (w_state_d != StHalt);
        case (w_state_d)
            StT0: begin
                w_strb_d.pc_out      = 1'b1;
                w_strb_d.mar_in      = 1'b1;
                w_strb_d.inc_pc      = 1'b1;
                w_strb_d.z_in        = 1'b1;
                w_alu_out_d[AluInc]  = 1'b1;
            end
            StT1: begin
                w_strb_d.zlow_out = 1'b1;
                w_strb_d.pc_in    = 1'b1;
                w_strb_d.read     = 1'b1;
                w_strb_d.mdr_in   = 1'b1;
            end
            StT1w: begin
                w_strb_d.read   = 1'b1;
                w_strb_d.mdr_in = 1'b1;
            end
            StT2: begin
                w_strb_d.mdr_out = 1'b1;
                w_strb_d.ir_in   = 1'b1;
            end
            StT3: begin
                w_strb_d.y_in = 1'b1;
                if (w_class_d == ClsHilo) w_rout_d[w_ra_d] = 1'b1;
                else                      w_rout_d[w_rb_d] = 1'b1;
            end
            StT4: begin
                w_strb_d.z_in = 1'b1;
                w_alu_out_d   = w_alu_d;
                // Unary ops take their operand from Y, so nothing drives the bus
                if (w_class_d == ClsBin)       w_rout_d[w_rc_d] = 1'b1;
                else if (w_class_d == ClsHilo) w_rout_d[w_rb_d] = 1'b1;
            end
            StT5: begin
                w_strb_d.zlow_out = 1'b1;
                if (w_class_d == ClsHilo) begin
                    w_strb_d.lo_in = 1'b1;
                end else begin
                    w_rin_d[w_ra_d] = 1'b1;
                    w_done_d        = 1'b1;
                end
            end
            StT6: begin
                w_strb_d.zhigh_out = 1'b1;
                w_strb_d.hi_in     = 1'b1;
                w_done_d           = 1'b1;
            end
            default: ;
        endcase
    end

    // State, latched fields and registered outputs; clear zeroes every strobe at once
    always_ff @(posedge i_clock or posedge i_clear) begin
        if (i_clear) begin
            r_state    <= StIdle;
            r_wait_cnt <= 3'd0;
            r_ra       <= '0;
            r_rb       <= '0;
            r_rc       <= '0;
            r_class    <= ClsBin;
            r_alu      <= '0;
            r_illegal  <= 1'b0;
            r_strb     <= '0;
            r_rin      <= '0;
            r_rout     <= '0;
            r_alu_out  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_cnt_d;
            r_ra       <= w_ra_d;
            r_rb       <= w_rb_d;
            r_rc       <= w_rc_d;
            r_class    <= w_class_d;
            r_alu      <= w_alu_d;
            r_illegal  <= w_illegal_d;
            r_strb     <= w_strb_d;
            r_rin      <= w_rin_d;
            r_rout     <= w_rout_d;
            r_alu_out  <= w_alu_out_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
        end
    end

    assign o_rin       = r_rin;
    assign o_rout      = r_rout;
    assign o_pc_out    = r_strb.pc_out;
    assign o_pc_in     = r_strb.pc_in;
    assign o_mar_in    = r_strb.mar_in;
    assign o_mdr_in    = r_strb.mdr_in;
    assign o_mdr_out   = r_strb.mdr_out;
    assign o_ir_in     = r_strb.ir_in;
    assign o_y_in      = r_strb.y_in;
    assign o_z_in      = r_strb.z_in;
    assign o_zlow_out  = r_strb.zlow_out;
    assign o_zhigh_out = r_strb.zhigh_out;
    assign o_hi_in     = r_strb.hi_in;
    assign o_lo_in     = r_strb.lo_in;
    assign o_read      = r_strb.read;
    assign o_inc_pc    = r_strb.inc_pc;
    assign o_alu_op    = r_alu_out;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_illegal   = r_illegal;

    // Shared bus: never more than one driver in any cycle
    logic [NREGS+3:0] w_bus_drivers;
    assign w_bus_drivers = {r_rout, r_strb.pc_out, r_strb.mdr_out, r_strb.zlow_out,
                            r_strb.zhigh_out};

    a_one_bus_driver: assert property (@(posedge i_clock) disable iff (i_clear)
        $onehot0(w_bus_drivers));

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer: one instance with no memory wait
// states and one with two, compared cycle by cycle against hand-built rows.
module tb_alu_instr_sequencer;

    // Strobe vector bit masks: {PCout,PCin,MARin,MDRin,MDRout,IRin,Yin,Zin,
    //                           Zlowout,Zhighout,HIin,LOin,Read,IncPC}
    localparam logic [13:0] S_T0   = 14'h2841; // PCout MARin Zin IncPC
    localparam logic [13:0] S_T1   = 14'h1422; // PCin MDRin Zlowout Read
    localparam logic [13:0] S_T1W  = 14'h0402; // MDRin Read
    localparam logic [13:0] S_T2   = 14'h0300; // MDRout IRin
    localparam logic [13:0] S_YIN  = 14'h0080;
    localparam logic [13:0] S_ZIN  = 14'h0040;
    localparam logic [13:0] S_ZLO  = 14'h0020;
    localparam logic [13:0] S_LO   = 14'h0024; // Zlowout LOin
    localparam logic [13:0] S_HI   = 14'h0018; // Zhighout HIin
    localparam logic [13:0] A_ADD  = 14'h0001;
    localparam logic [13:0] A_NEG  = 14'h0200;
    localparam logic [13:0] A_MUL  = 14'h0800;
    localparam logic [13:0] A_INC  = 14'h2000;

    localparam logic [31:0] IR_NEG = 32'h7238_0000; // NEG R4,R7
    localparam logic [31:0] IR_ADD = 32'h1A92_0000; // ADD R5,R2,R4
    localparam logic [31:0] IR_MUL = 32'h7988_0000; // MUL R3,R1
    localparam logic [31:0] IR_BAD = 32'hF800_0000; // opcode 11111

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instance 0: MEM_WAIT=0
    logic        clear0 = 1'b1, start0 = 1'b0, run0 = 1'b0;
    logic [31:0] ir0 = '0;
    wire  [15:0] rin0, rout0;
    wire  [13:0] s0, alu0;
    wire         done0, busy0, ill0;
    wire  [62:0] obs0 = {s0, alu0, rin0, rout0, done0, busy0, ill0};

    // Instance 2: MEM_WAIT=2
    logic        clear2 = 1'b1, start2 = 1'b0, run2 = 1'b0;
    logic [31:0] ir2 = '0;
    wire  [15:0] rin2, rout2;
    wire  [13:0] s2, alu2;
    wire         done2, busy2, ill2;
    wire  [62:0] obs2 = {s2, alu2, rin2, rout2, done2, busy2, ill2};

    alu_instr_sequencer #(.NREGS(16), .REG_W(4), .MEM_WAIT(0), .OP_W(5)) dut0 (
        .i_clock(clk), .i_clear(clear0), .i_start(start0), .i_run(run0), .i_ir(ir0),
        .o_rin(rin0), .o_rout(rout0),
        .o_pc_out(s0[13]), .o_pc_in(s0[12]), .o_mar_in(s0[11]), .o_mdr_in(s0[10]),
        .o_mdr_out(s0[9]), .o_ir_in(s0[8]), .o_y_in(s0[7]), .o_z_in(s0[6]),
        .o_zlow_out(s0[5]), .o_zhigh_out(s0[4]), .o_hi_in(s0[3]), .o_lo_in(s0[2]),
        .o_read(s0[1]), .o_inc_pc(s0[0]),
        .o_alu_op(alu0), .o_busy(busy0), .o_done(done0), .o_illegal(ill0)
    );

    alu_instr_sequencer #(.NREGS(16), .REG_W(4), .MEM_WAIT(2), .OP_W(5)) dut2 (
        .i_clock(clk), .i_clear(clear2), .i_start(start2), .i_run(run2), .i_ir(ir2),
        .o_rin(rin2), .o_rout(rout2),
        .o_pc_out(s2[13]), .o_pc_in(s2[12]), .o_mar_in(s2[11]), .o_mdr_in(s2[10]),
        .o_mdr_out(s2[9]), .o_ir_in(s2[8]), .o_y_in(s2[7]), .o_z_in(s2[6]),
        .o_zlow_out(s2[5]), .o_zhigh_out(s2[4]), .o_hi_in(s2[3]), .o_lo_in(s2[2]),
        .o_read(s2[1]), .o_inc_pc(s2[0]),
        .o_alu_op(alu2), .o_busy(busy2), .o_done(done2), .o_illegal(ill2)
    );

    function automatic logic [62:0] row(input logic [13:0] s, input logic [13:0] a,
                                        input logic [15:0] rin, input logic [15:0] rout,
                                        input logic d, input logic b, input logic il);
        return {s, a, rin, rout, d, b, il};
    endfunction

    task automatic test_reset;
        @(negedge clk);
        tests++;
        if (obs0 !== 63'd0) begin
            $display("FAIL reset_dut0: got %h expected %h", obs0, 63'd0);
            fails++;
        end
        tests++;
        if (obs2 !== 63'd0) begin
            $display("FAIL reset_dut2: got %h expected %h", obs2, 63'd0);
            fails++;
        end
        clear0 = 1'b0;
        clear2 = 1'b0;
    endtask

    task automatic test_neg;
        logic [62:0] rows [8];
        rows = '{row(S_T0, A_INC, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T1, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T2, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row('0, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_YIN, '0, 16'h0, 16'h0080, 1'b0, 1'b1, 1'b0),
                 row(S_ZIN, A_NEG, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_ZLO, '0, 16'h0010, 16'h0, 1'b1, 1'b1, 1'b0),
                 row('0, '0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0)};
        ir0 = IR_NEG;
        start0 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            tests++;
            if (obs0 !== rows[k]) begin
                $display("FAIL neg step %0d: got %h expected %h", k, obs0, rows[k]);
                fails++;
            end
        end
    endtask

    task automatic test_add_wait;
        logic [62:0] rows [10];
        rows = '{row(S_T0, A_INC, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T1, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T1W, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T1W, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T2, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row('0, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_YIN, '0, 16'h0, 16'h0004, 1'b0, 1'b1, 1'b0),
                 row(S_ZIN, A_ADD, 16'h0, 16'h0010, 1'b0, 1'b1, 1'b0),
                 row(S_ZLO, '0, 16'h0020, 16'h0, 1'b1, 1'b1, 1'b0),
                 row('0, '0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0)};
        ir2 = IR_ADD;
        start2 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            tests++;
            if (obs2 !== rows[k]) begin
                $display("FAIL add_wait step %0d: got %h expected %h", k, obs2, rows[k]);
                fails++;
            end
        end
    endtask

    task automatic test_mul;
        logic [62:0] rows [9];
        rows = '{row(S_T0, A_INC, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T1, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T2, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row('0, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_YIN, '0, 16'h0, 16'h0008, 1'b0, 1'b1, 1'b0),
                 row(S_ZIN, A_MUL, 16'h0, 16'h0002, 1'b0, 1'b1, 1'b0),
                 row(S_LO, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_HI, '0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0),
                 row('0, '0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0)};
        ir0 = IR_MUL;
        start0 = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            tests++;
            if (obs0 !== rows[k]) begin
                $display("FAIL mul step %0d: got %h expected %h", k, obs0, rows[k]);
                fails++;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [62:0] rows [15];
        rows = '{row(S_T0, A_INC, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T1, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T2, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row('0, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_YIN, '0, 16'h0, 16'h0080, 1'b0, 1'b1, 1'b0),
                 row(S_ZIN, A_NEG, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_ZLO, '0, 16'h0010, 16'h0, 1'b1, 1'b1, 1'b0),
                 row(S_T0, A_INC, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T1, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_T2, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row('0, '0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0),
                 row(S_YIN, '0, 16'h0, 16'h0004, 1'b0, 1'b1, 1'b0),
                 row(S_ZIN, A_ADD, 16'h0, 16'h0010, 1'b0, 1'b1, 1'b0),
                 row(S_ZLO, '0, 16'h0020, 16'h0, 1'b1, 1'b1, 1'b0),
                 row('0, '0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0)};
        ir0 = IR_NEG;
        run0 = 1'b1;
        start0 = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            tests++;
            if (obs0 !== rows[k]) begin
                $display("FAIL back_to_back step %0d: got %h expected %h", k, obs0, rows[k]);
                fails++;
            end
            if (k == 6) ir0 = IR_ADD;
            if (k == 7) run0 = 1'b0;
        end
    endtask

    task automatic test_illegal;
        logic [62:0] halt_row;
        logic [62:0] t0_row;
        halt_row = row('0, '0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        t0_row   = row(S_T0, A_INC, 16'h0, 16'h0, 1'b0, 1'b1, 1'b0);
        ir0 = IR_BAD;
        start0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        tests++;
        if (obs0 !== halt_row) begin
            $display("FAIL illegal_halt: got %h expected %h", obs0, halt_row);
            fails++;
        end
        // start must be ignored while halted
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (obs0 !== halt_row) begin
                $display("FAIL illegal_start_ignored %0d: got %h expected %h", k, obs0, halt_row);
                fails++;
            end
            @(negedge clk);
        end
        #2 clear0 = 1'b1;
        #1;
        tests++;
        if (obs0 !== 63'd0) begin
            $display("FAIL illegal_clear: got %h expected %h", obs0, 63'd0);
            fails++;
        end
        @(negedge clk);
        clear0 = 1'b0;
        ir0 = IR_NEG;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        tests++;
        if (obs0 !== t0_row) begin
            $display("FAIL illegal_restart: got %h expected %h", obs0, t0_row);
            fails++;
        end
        for (int k = 0; k < 7; k++) @(negedge clk);
    endtask

    task automatic test_clear_mid;
        logic [62:0] t4_row;
        t4_row = row(S_ZIN, A_ADD, 16'h0, 16'h0010, 1'b0, 1'b1, 1'b0);
        ir0 = IR_ADD;
        start0 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        tests++;
        if (obs0 !== t4_row) begin
            $display("FAIL clear_mid_t4: got %h expected %h", obs0, t4_row);
            fails++;
        end
        #2 clear0 = 1'b1;
        #1;
        tests++;
        if (obs0 !== 63'd0) begin
            $display("FAIL clear_mid_async: got %h expected %h", obs0, 63'd0);
            fails++;
        end
        @(negedge clk);
        clear0 = 1'b0;
        @(negedge clk);
        tests++;
        if (obs0 !== 63'd0) begin
            $display("FAIL clear_mid_idle: got %h expected %h", obs0, 63'd0);
            fails++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_neg();
        test_add_wait();
        test_mul();
        test_back_to_back();
        test_illegal();
        test_clear_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
